datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl.sv | 134 +++++++++++++
 tb/tb_datapath_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Issue controller for a two-instruction RV32 subset (LUI, ADD).
// Accepts one instruction, sequences it through DEC/ALU/WR and drives the datapath controls.
module datapath_ctrl #(
    parameter int LENGTH   = 32,
    parameter int NREGS    = 32,
    parameter int SEL_BITS = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [SEL_BITS-1:0] addr_a,
    output logic [SEL_BITS-1:0] addr_b,
    output logic [SEL_BITS-1:0] addr_d,
    output logic                wr_regfile,
    output logic [LENGTH-1:0]   imm,
    output logic                f,
    output logic                busy,
    output logic                illegal,
    output logic [15:0]         retired
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DEC  = 2'd1;
    localparam logic [1:0] ALU  = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_REG = 7'b0110011;

    logic [1:0]          state_q, state_d;
    logic [SEL_BITS-1:0] addr_a_q, addr_a_d;
    logic [SEL_BITS-1:0] addr_b_q, addr_b_d;
    logic [SEL_BITS-1:0] addr_d_q, addr_d_d;
    logic [LENGTH-1:0]   imm_q, imm_d;
    logic                f_q, f_d;
    logic                illegal_q, illegal_d;
    logic [15:0]         retired_q, retired_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_lui;
    logic       is_add;
    logic       handshake;
    logic       accept;
    logic       reject;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_lui = (opcode == OP_LUI);
    assign is_add = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);

    // Ready is gated by reset so no handshake can be seen while the block is held in reset.
    assign instr_ready = !reset && ((state_q == IDLE) || (state_q == WR));
    assign handshake   = instr_valid && instr_ready;
    assign accept      = handshake && (is_lui || is_add);
    assign reject      = handshake && !(is_lui || is_add);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? DEC : IDLE;
            DEC:     state_d = ALU;
            ALU:     state_d = WR;
            WR:      state_d = accept ? DEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls only change on a legal acceptance; illegal words leave them untouched.
    always_comb begin
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_d_d = addr_d_q;
        imm_d    = imm_q;
        f_d      = f_q;
        if (accept) begin
            addr_d_d = SEL_BITS'(instr[11:7]);
            if (is_lui) begin
                addr_a_d = '0;
                addr_b_d = '0;
                imm_d    = LENGTH'({instr[31:12], 12'b0});
                f_d      = 1'b1;
            end else begin
                addr_a_d = SEL_BITS'(instr[19:15]);
                addr_b_d = SEL_BITS'(instr[24:20]);
                imm_d    = '0;
                f_d      = 1'b0;
            end
        end
    end

    always_comb begin
        illegal_d = reject;
        retired_d = (state_q == WR) ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_d_q  <= '0;
            imm_q     <= '0;
            f_q       <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            addr_d_q  <= addr_d_d;
            imm_q     <= imm_d;
            f_q       <= f_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Write enable decodes straight from state so an async reset drops it at once.
    assign wr_regfile = (state_q == WR);
    assign busy       = (state_q != IDLE);
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign addr_d     = addr_d_q;
    assign imm        = imm_q;
    assign f          = f_q;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed testbench for datapath_ctrl: each task drives one scenario and checks
// outputs against hand-computed values at the falling clock edge.
module tb_datapath_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_d;
    logic        wr_regfile;
    logic [31:0] imm;
    logic        f;
    logic        busy;
    logic        illegal;
    logic [15:0] retired;

    int checks;
    int errors;

    datapath_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_d     (addr_d),
        .wr_regfile (wr_regfile),
        .imm        (imm),
        .f          (f),
        .busy       (busy),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a word for one rising edge, then withdraw it; returns on the next falling edge.
    task automatic applyStimulus(input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b exp 0", instr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
        checks++; if (wr_regfile !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr got %b exp 0", wr_regfile); end
        checks++; if (retired !== 16'h0000) begin errors++; $display("[TB] FAIL rst_retired got %h exp 0000", retired); end
        checks++; if ({addr_a, addr_b, addr_d, imm, f, illegal} !== 49'd0) begin errors++; $display("[TB] FAIL rst_outputs got %h exp 0", {addr_a, addr_b, addr_d, imm, f, illegal}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b exp 1", instr_ready); end
        @(negedge clk);
    endtask

    task automatic test_lui();
        applyStimulus(32'hCAC00037);
        checks++; if (imm !== 32'hCAC00000) begin errors++; $display("[TB] FAIL lui_imm got %h exp cac00000", imm); end
        checks++; if (f !== 1'b1) begin errors++; $display("[TB] FAIL lui_f got %b exp 1", f); end
        checks++; if ({addr_a, addr_b, addr_d} !== 15'd0) begin errors++; $display("[TB] FAIL lui_addr got %h exp 0", {addr_a, addr_b, addr_d}); end
        checks++; if ({busy, instr_ready, wr_regfile} !== 3'b100) begin errors++; $display("[TB] FAIL lui_dec_flags got %b exp 100", {busy, instr_ready, wr_regfile}); end
        @(negedge clk);
        checks++; if ({busy, instr_ready, wr_regfile} !== 3'b100) begin errors++; $display("[TB] FAIL lui_alu_flags got %b exp 100", {busy, instr_ready, wr_regfile}); end
        @(negedge clk);
        checks++; if ({busy, instr_ready, wr_regfile} !== 3'b111) begin errors++; $display("[TB] FAIL lui_wr_flags got %b exp 111", {busy, instr_ready, wr_regfile}); end
        @(negedge clk);
        checks++; if ({busy, wr_regfile} !== 2'b00) begin errors++; $display("[TB] FAIL lui_idle_flags got %b exp 00", {busy, wr_regfile}); end
        checks++; if (retired !== 16'd1) begin errors++; $display("[TB] FAIL lui_retired got %0d exp 1", retired); end
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1;
        instr       = 32'h010000B7;
        @(negedge clk);
        instr       = 32'h00100133;
        checks++; if ({addr_d, f, imm} !== {5'd1, 1'b1, 32'h01000000}) begin errors++; $display("[TB] FAIL b2b_lui got %h exp %h", {addr_d, f, imm}, {5'd1, 1'b1, 32'h01000000}); end
        @(negedge clk);
        checks++; if (wr_regfile !== 1'b0) begin errors++; $display("[TB] FAIL b2b_alu_wr got %b exp 0", wr_regfile); end
        @(negedge clk);
        checks++; if ({wr_regfile, instr_ready, addr_d} !== {2'b11, 5'd1}) begin errors++; $display("[TB] FAIL b2b_wr1 got %h exp %h", {wr_regfile, instr_ready, addr_d}, {2'b11, 5'd1}); end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({addr_a, addr_b, addr_d} !== {5'd0, 5'd1, 5'd2}) begin errors++; $display("[TB] FAIL b2b_add_addr got %h exp %h", {addr_a, addr_b, addr_d}, {5'd0, 5'd1, 5'd2}); end
        checks++; if ({f, imm} !== 33'd0) begin errors++; $display("[TB] FAIL b2b_add_fimm got %h exp 0", {f, imm}); end
        checks++; if ({busy, wr_regfile} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_dec_flags got %b exp 10", {busy, wr_regfile}); end
        checks++; if (retired !== 16'd2) begin errors++; $display("[TB] FAIL b2b_retired1 got %0d exp 2", retired); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (wr_regfile !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wr2 got %b exp 1", wr_regfile); end
        @(negedge clk);
        checks++; if ({busy, wr_regfile} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_end_flags got %b exp 00", {busy, wr_regfile}); end
        checks++; if (retired !== 16'd3) begin errors++; $display("[TB] FAIL b2b_retired2 got %0d exp 3", retired); end
    endtask

    task automatic test_illegal();
        applyStimulus(32'h00000013);
        checks++; if ({illegal, busy, wr_regfile} !== 3'b100) begin errors++; $display("[TB] FAIL ill_pulse got %b exp 100", {illegal, busy, wr_regfile}); end
        checks++; if ({addr_a, addr_b, addr_d, f, imm} !== {5'd0, 5'd1, 5'd2, 1'b0, 32'd0}) begin errors++; $display("[TB] FAIL ill_outputs got %h exp %h", {addr_a, addr_b, addr_d, f, imm}, {5'd0, 5'd1, 5'd2, 1'b0, 32'd0}); end
        @(negedge clk);
        checks++; if ({illegal, wr_regfile} !== 2'b00) begin errors++; $display("[TB] FAIL ill_clear got %b exp 00", {illegal, wr_regfile}); end
        checks++; if (retired !== 16'd3) begin errors++; $display("[TB] FAIL ill_retired got %0d exp 3", retired); end
        applyStimulus(32'h40000033);
        checks++; if ({illegal, busy} !== 2'b10) begin errors++; $display("[TB] FAIL sub_illegal got %b exp 10", {illegal, busy}); end
        @(negedge clk);
    endtask

    task automatic test_illegal_in_wr();
        applyStimulus(32'h123452B7);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'h00000013;
        @(negedge clk);
        checks++; if ({wr_regfile, instr_ready, illegal} !== 3'b110) begin errors++; $display("[TB] FAIL iwr_wr got %b exp 110", {wr_regfile, instr_ready, illegal}); end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({illegal, busy, wr_regfile} !== 3'b100) begin errors++; $display("[TB] FAIL iwr_pulse got %b exp 100", {illegal, busy, wr_regfile}); end
        checks++; if (retired !== 16'd4) begin errors++; $display("[TB] FAIL iwr_retired got %0d exp 4", retired); end
        checks++; if ({addr_d, f, imm} !== {5'd5, 1'b1, 32'h12345000}) begin errors++; $display("[TB] FAIL iwr_outputs got %h exp %h", {addr_d, f, imm}, {5'd5, 1'b1, 32'h12345000}); end
        @(negedge clk);
        checks++; if ({illegal, busy} !== 2'b00) begin errors++; $display("[TB] FAIL iwr_after got %b exp 00", {illegal, busy}); end
    endtask

    task automatic test_valid_toggle();
        applyStimulus(32'hABCDE1B7);
        instr_valid = 1'b1;
        instr       = 32'h00100133;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({addr_d, f, imm} !== {5'd3, 1'b1, 32'hABCDE000}) begin errors++; $display("[TB] FAIL tog_alu got %h exp %h", {addr_d, f, imm}, {5'd3, 1'b1, 32'hABCDE000}); end
        @(negedge clk);
        checks++; if ({wr_regfile, addr_d, f, imm} !== {1'b1, 5'd3, 1'b1, 32'hABCDE000}) begin errors++; $display("[TB] FAIL tog_wr got %h exp %h", {wr_regfile, addr_d, f, imm}, {1'b1, 5'd3, 1'b1, 32'hABCDE000}); end
        @(negedge clk);
        checks++; if ({busy, retired} !== {1'b0, 16'd5}) begin errors++; $display("[TB] FAIL tog_end got %h exp %h", {busy, retired}, {1'b0, 16'd5}); end
    endtask

    task automatic test_reset_mid_alu();
        applyStimulus(32'h00100133);
        @(negedge clk);
        checks++; if ({busy, wr_regfile, addr_b, addr_d} !== {2'b10, 5'd1, 5'd2}) begin errors++; $display("[TB] FAIL rma_alu got %h exp %h", {busy, wr_regfile, addr_b, addr_d}, {2'b10, 5'd1, 5'd2}); end
        reset = 1'b1;
        #1;
        checks++; if ({busy, wr_regfile, instr_ready, illegal} !== 4'b0000) begin errors++; $display("[TB] FAIL rma_flags got %b exp 0000", {busy, wr_regfile, instr_ready, illegal}); end
        checks++; if ({addr_a, addr_b, addr_d, f, imm, retired} !== 64'd0) begin errors++; $display("[TB] FAIL rma_outputs got %h exp 0", {addr_a, addr_b, addr_d, f, imm, retired}); end
        @(negedge clk);
        checks++; if (wr_regfile !== 1'b0) begin errors++; $display("[TB] FAIL rma_no_wr got %b exp 0", wr_regfile); end
        reset = 1'b0;
        applyStimulus(32'h010000B7);
        checks++; if ({busy, addr_d} !== {1'b1, 5'd1}) begin errors++; $display("[TB] FAIL rma_first_hs got %h exp %h", {busy, addr_d}, {1'b1, 5'd1}); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (retired !== 16'd1) begin errors++; $display("[TB] FAIL rma_retired got %0d exp 1", retired); end
    endtask

    task automatic test_retired_wrap();
        dut.retired_q = 16'hFFFE;
        applyStimulus(32'hCAC00037);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (retired !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_ffff got %h exp ffff", retired); end
        applyStimulus(32'hCAC00037);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (retired !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero got %h exp 0000", retired); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        test_reset();
        test_lui();
        test_back_to_back();
        test_illegal();
        test_illegal_in_wr();
        test_valid_toggle();
        test_reset_mid_alu();
        test_retired_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
